// File: rtl/bolucu_iter.sv
// Iterative radix-2 restoring divider with RISC-V M-extension DIV/REM semantics.
// One operation in flight; quotient and remainder are registered and held until the next result.
module bolucu_iter #(
    parameter int unsigned VERI_BIT = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [VERI_BIT-1:0] bolunen_i,
    input  logic                bolunen_isaretli_i,
    input  logic [VERI_BIT-1:0] bolen_i,
    input  logic                bolen_isaretli_i,
    input  logic                islem_gecerli_i,
    output logic                mesgul_o,
    output logic [VERI_BIT-1:0] bolum_o,
    output logic [VERI_BIT-1:0] kalan_o,
    output logic                sonuc_gecerli_o
);

    localparam int unsigned SayW = $clog2(VERI_BIT) + 1;
    localparam logic [VERI_BIT-1:0] MinNeg = {1'b1, {(VERI_BIT-1){1'b0}}};

    typedef enum logic [1:0] {StBosta, StHesapla, StDuzelt} durum_e;

    durum_e              durum_q;
    logic [VERI_BIT-1:0] q_q;
    logic [VERI_BIT-1:0] r_q;
    logic [VERI_BIT:0]   bolen_q;
    logic                neg_q_q;
    logic                neg_r_q;
    logic [SayW-1:0]     sayac_q;
    logic                mesgul_q;
    logic                gecerli_q;
    logic [VERI_BIT-1:0] bolum_q;
    logic [VERI_BIT-1:0] kalan_q;

    logic                isaret0;
    logic                isaret1;
    logic [VERI_BIT-1:0] bolunen_abs;
    logic [VERI_BIT:0]   bolen_ext;
    logic [VERI_BIT:0]   bolen_abs;
    logic                bolen_sifir;
    logic                tasma;
    logic [VERI_BIT:0]   r_kay;
    logic                buyuk_esit;
    logic [VERI_BIT-1:0] fark;
    logic [VERI_BIT-1:0] bolum_son;
    logic [VERI_BIT-1:0] kalan_son;

    always_comb begin
        isaret0     = bolunen_i[VERI_BIT-1] & bolunen_isaretli_i;
        isaret1     = bolen_i[VERI_BIT-1] & bolen_isaretli_i;
        // |MIN_NEG| wraps back to MIN_NEG, which is the correct magnitude read as unsigned.
        bolunen_abs = isaret0 ? -bolunen_i : bolunen_i;
        bolen_ext   = {isaret1, bolen_i};
        bolen_abs   = isaret1 ? -bolen_ext : bolen_ext;
        bolen_sifir = (bolen_i == '0);
        tasma       = isaret0 & isaret1 & (bolunen_i == MinNeg) & (bolen_i == '1);
        r_kay       = {r_q, q_q[VERI_BIT-1]};
        buyuk_esit  = (r_kay >= bolen_q);
        // The true difference is below the divisor, so it always fits in VERI_BIT bits.
        fark        = r_kay[VERI_BIT-1:0] - bolen_q[VERI_BIT-1:0];
        bolum_son   = neg_q_q ? -q_q : q_q;
        kalan_son   = neg_r_q ? -r_q : r_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            durum_q   <= StBosta;
            q_q       <= '0;
            r_q       <= '0;
            bolen_q   <= '0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            sayac_q   <= '0;
            mesgul_q  <= 1'b0;
            gecerli_q <= 1'b0;
            bolum_q   <= '0;
            kalan_q   <= '0;
        end else begin
            gecerli_q <= 1'b0;
            unique case (durum_q)
                StBosta: begin
                    if (islem_gecerli_i) begin
                        mesgul_q <= 1'b1;
                        bolen_q  <= bolen_abs;
                        sayac_q  <= SayW'(VERI_BIT);
                        if (bolen_sifir) begin
                            q_q     <= '1;
                            r_q     <= bolunen_i;
                            neg_q_q <= 1'b0;
                            neg_r_q <= 1'b0;
                            durum_q <= StDuzelt;
                        end else if (tasma) begin
                            q_q     <= MinNeg;
                            r_q     <= '0;
                            neg_q_q <= 1'b0;
                            neg_r_q <= 1'b0;
                            durum_q <= StDuzelt;
                        end else begin
                            q_q     <= bolunen_abs;
                            r_q     <= '0;
                            neg_q_q <= isaret0 ^ isaret1;
                            neg_r_q <= isaret0;
                            durum_q <= StHesapla;
                        end
                    end
                end
                StHesapla: begin
                    q_q     <= {q_q[VERI_BIT-2:0], buyuk_esit};
                    r_q     <= buyuk_esit ? fark : r_kay[VERI_BIT-1:0];
                    sayac_q <= sayac_q - SayW'(1);
                    if (sayac_q == SayW'(1)) begin
                        durum_q <= StDuzelt;
                    end
                end
                StDuzelt: begin
                    bolum_q   <= bolum_son;
                    kalan_q   <= kalan_son;
                    gecerli_q <= 1'b1;
                    mesgul_q  <= 1'b0;
                    durum_q   <= StBosta;
                end
                default: durum_q <= StBosta;
            endcase
        end
    end

    assign mesgul_o        = mesgul_q;
    assign sonuc_gecerli_o = gecerli_q;
    assign bolum_o         = bolum_q;
    assign kalan_o         = kalan_q;

endmodule

// File: tb/tb_bolucu_iter.sv
// Bench for bolucu_iter: directed corner cases, busy/back-to-back handling, mid-operation
// reset and randomized operands against an arithmetic reference model.
module tb_bolucu_iter;

    localparam int unsigned W = 32;
    localparam int NormLat = W + 1;
    localparam int OzelLat = 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] bolunen = '0;
    logic         bolunen_s = 1'b0;
    logic [W-1:0] bolen = '0;
    logic         bolen_s = 1'b0;
    logic         islem = 1'b0;
    logic         mesgul;
    logic [W-1:0] bolum;
    logic [W-1:0] kalan;
    logic         gecerli;

    int checks = 0;
    int errors = 0;

    bolucu_iter #(.VERI_BIT(W)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .bolunen_i         (bolunen),
        .bolunen_isaretli_i(bolunen_s),
        .bolen_i           (bolen),
        .bolen_isaretli_i  (bolen_s),
        .islem_gecerli_i   (islem),
        .mesgul_o          (mesgul),
        .bolum_o           (bolum),
        .kalan_o           (kalan),
        .sonuc_gecerli_o   (gecerli)
    );

    always #5 clk = ~clk;

    // Reference: plain 64-bit division, which truncates toward zero with remainder sign of dividend.
    function automatic void model(input logic [W-1:0] n, input logic ns, input logic [W-1:0] d,
                                  input logic ds, output logic [W-1:0] q, output logic [W-1:0] r);
        longint nn;
        longint dd;
        nn = ns ? longint'($signed(n)) : longint'({32'b0, n});
        dd = ds ? longint'($signed(d)) : longint'({32'b0, d});
        if (dd == 0) begin
            q = '1;
            r = n;
        end else if (ns && ds && nn == -longint'(64'h8000_0000) && dd == -1) begin
            q = 32'h8000_0000;
            r = '0;
        end else begin
            q = 32'(nn / dd);
            r = 32'(nn % dd);
        end
    endfunction

    // Issue one request and wait (bounded) for the result; lat counts edges after acceptance.
    task automatic run_op(input logic [W-1:0] n, input logic ns, input logic [W-1:0] d,
                          input logic ds, output logic [W-1:0] gq, output logic [W-1:0] gr,
                          output int lat);
        @(negedge clk);
        bolunen = n; bolunen_s = ns; bolen = d; bolen_s = ds; islem = 1'b1;
        @(posedge clk); #1;
        islem = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!gecerli && lat < 100);
        gq = bolum;
        gr = kalan;
        checks++;
        if (gecerli !== 1'b1) begin
            errors++;
            $display("FAIL timeout: no sonuc_gecerli_o within %0d edges for %h/%h", lat, n, d);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        islem = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (mesgul !== 1'b0) begin errors++; $display("FAIL reset_mesgul got %b want 0", mesgul); end
        checks++; if (gecerli !== 1'b0) begin errors++; $display("FAIL reset_gecerli got %b want 0", gecerli); end
        checks++; if (bolum !== '0) begin errors++; $display("FAIL reset_bolum got %h want 0", bolum); end
        checks++; if (kalan !== '0) begin errors++; $display("FAIL reset_kalan got %h want 0", kalan); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_directed();
        logic [W-1:0] tn [8] = '{32'd100, 32'hFFFF_FF9C, 32'd100, 32'h1234_5678, 32'h1234_5678,
                                 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        logic         tns [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [W-1:0] td [8] = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'd0, 32'd0,
                                 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        logic         tds [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [W-1:0] eq [8] = '{32'd14, 32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'h8000_0000, 32'd0, 32'hFFFF_FFFF};
        logic [W-1:0] er [8] = '{32'd2, 32'hFFFF_FFFE, 32'd2, 32'h1234_5678, 32'h1234_5678,
                                 32'd0, 32'h8000_0000, 32'h8000_0000};
        int           elat [8] = '{NormLat, NormLat, NormLat, OzelLat, OzelLat,
                                   OzelLat, NormLat, OzelLat};
        logic [W-1:0] gq;
        logic [W-1:0] gr;
        int           lat;
        for (int i = 0; i < 8; i++) begin
            run_op(tn[i], tns[i], td[i], tds[i], gq, gr, lat);
            checks++; if (gq !== eq[i]) begin errors++; $display("FAIL dir%0d_bolum got %h want %h", i, gq, eq[i]); end
            checks++; if (gr !== er[i]) begin errors++; $display("FAIL dir%0d_kalan got %h want %h", i, gr, er[i]); end
            checks++; if (lat !== elat[i]) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, elat[i]); end
            @(posedge clk); #1;
            checks++; if (gecerli !== 1'b0) begin errors++; $display("FAIL dir%0d_pulse_width got %b want 0", i, gecerli); end
            checks++; if (bolum !== eq[i]) begin errors++; $display("FAIL dir%0d_hold got %h want %h", i, bolum, eq[i]); end
        end
    endtask

    // Request kept high through a whole operation with changing operands, then picked up in the pulse cycle.
    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        bolunen = 32'd1000; bolunen_s = 1'b0; bolen = 32'd3; bolen_s = 1'b0; islem = 1'b1;
        @(posedge clk); #1;
        checks++; if (mesgul !== 1'b1) begin errors++; $display("FAIL b2b_mesgul got %b want 1", mesgul); end
        bolunen = 32'd77; bolen = 32'd5;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!gecerli && lat < 100);
        checks++; if (lat !== NormLat) begin errors++; $display("FAIL b2b_first_latency got %0d want %0d", lat, NormLat); end
        checks++; if (bolum !== 32'd333 || kalan !== 32'd1) begin
            errors++; $display("FAIL b2b_first got %0d r %0d want 333 r 1", bolum, kalan);
        end
        // Still in the pulse cycle with islem high: acceptance happens at the edge ending it.
        @(posedge clk); #1;
        checks++; if (mesgul !== 1'b1) begin errors++; $display("FAIL b2b_second_accept got %b want 1", mesgul); end
        islem = 1'b0;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!gecerli && lat < 100);
        checks++; if (lat !== NormLat) begin errors++; $display("FAIL b2b_second_latency got %0d want %0d", lat, NormLat); end
        checks++; if (bolum !== 32'd15 || kalan !== 32'd2) begin
            errors++; $display("FAIL b2b_second got %0d r %0d want 15 r 2", bolum, kalan);
        end
        @(posedge clk); #1;
        checks++; if (mesgul !== 1'b0 || gecerli !== 1'b0) begin
            errors++; $display("FAIL b2b_idle got mesgul %b gecerli %b want 0 0", mesgul, gecerli);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [W-1:0] gq;
        logic [W-1:0] gr;
        int           lat;
        int           darbe;
        @(negedge clk);
        bolunen = 32'd1000; bolunen_s = 1'b0; bolen = 32'd3; bolen_s = 1'b0; islem = 1'b1;
        @(posedge clk); #1;
        islem = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (mesgul !== 1'b0 || gecerli !== 1'b0 || bolum !== '0 || kalan !== '0) begin
            errors++; $display("FAIL midreset_outputs got %b %b %h %h want 0 0 0 0", mesgul, gecerli, bolum, kalan);
        end
        @(negedge clk);
        rst = 1'b1;
        darbe = 0;
        repeat (40) begin @(posedge clk); #1; if (gecerli) darbe++; end
        checks++; if (darbe !== 0) begin errors++; $display("FAIL midreset_stale_pulse got %0d want 0", darbe); end
        run_op(32'd5, 1'b0, 32'd2, 1'b0, gq, gr, lat);
        checks++; if (gq !== 32'd2 || gr !== 32'd1) begin errors++; $display("FAIL midreset_next got %0d r %0d want 2 r 1", gq, gr); end
        checks++; if (lat !== NormLat) begin errors++; $display("FAIL midreset_latency got %0d want %0d", lat, NormLat); end
    endtask

    task automatic test_random();
        logic [W-1:0] n;
        logic [W-1:0] d;
        logic         ns;
        logic         ds;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic [W-1:0] gq;
        logic [W-1:0] gr;
        int           lat;
        for (int i = 0; i < 1500; i++) begin
            n = $urandom;
            d = $urandom;
            ns = 1'($urandom_range(0, 1));
            ds = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: d = '0;
                1: begin n = 32'h8000_0000; d = '1; end
                2: begin n = $urandom_range(0, 40); d = $urandom_range(1, 9); end
                3: d = $urandom_range(1, 255);
                4: d = -$urandom_range(1, 255);
                default: ;
            endcase
            model(n, ns, d, ds, eq, er);
            run_op(n, ns, d, ds, gq, gr, lat);
            checks++;
            if (gq !== eq || gr !== er) begin
                errors++;
                $display("FAIL rand%0d %h(%b)/%h(%b) got %h r %h want %h r %h", i, n, ns, d, ds, gq, gr, eq, er);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
